// File: rtl/i2c_req_scheduler_if.sv
// ============================================================================
// Module   : i2c_req_scheduler_if
// Brief    : Requester-side and master-core-side signals of the I2C request
//            scheduler; the scheduler uses the slave view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_req_scheduler_if #(
    parameter int LEN_W = 4
);
    logic [1:0]       req;
    logic [1:0]       rnw;
    logic [6:0]       addr0;
    logic [6:0]       addr1;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [7:0]       wdata0;
    logic [7:0]       wdata1;
    logic [1:0]       wr_ack;
    logic [7:0]       rd_data;
    logic [1:0]       rd_vld;
    logic [1:0]       done;
    logic             err;
    logic [1:0]       grant;
    logic             m_en;
    logic             m_start;
    logic             m_stop;
    logic             m_mode;
    logic [6:0]       m_address;
    logic [7:0]       m_wdata;
    logic [7:0]       m_rdata;
    logic             m_byte_done;
    logic             m_nack;
    logic             m_idle;

    modport slave (
        input  req, rnw, addr0, addr1, len0, len1, wdata0, wdata1,
               m_rdata, m_byte_done, m_nack, m_idle,
        output wr_ack, rd_data, rd_vld, done, err, grant,
               m_en, m_start, m_stop, m_mode, m_address, m_wdata
    );

    modport master (
        output req, rnw, addr0, addr1, len0, len1, wdata0, wdata1,
               m_rdata, m_byte_done, m_nack, m_idle,
        input  wr_ack, rd_data, rd_vld, done, err, grant,
               m_en, m_start, m_stop, m_mode, m_address, m_wdata
    );
endinterface

`default_nettype wire

// File: rtl/i2c_req_scheduler.sv
// ============================================================================
// Module   : i2c_req_scheduler
// Brief    : Two-requester round-robin arbiter and byte sequencer driving the
//            I2C master core, with per-transaction done/error status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_req_scheduler #(
    parameter int LEN_W   = 4,
    parameter int TO_W    = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               reset_n,
    i2c_req_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_XFER   = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam logic [TO_W-1:0]  c_WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] c_CNT_ONE = LEN_W'(1);

    state_t           r_state,   w_state;
    logic             r_owner,   w_owner;
    logic             r_last,    w_last;
    logic [6:0]       r_addr,    w_addr;
    logic             r_rnw,     w_rnw;
    logic [LEN_W-1:0] r_len,     w_len;
    logic [LEN_W-1:0] r_cnt,     w_cnt;
    logic             r_err,     w_err;
    logic [TO_W-1:0]  r_wd,      w_wd;
    logic             r_wload,   w_wload;
    logic [1:0]       r_wr_ack,  w_wr_ack;
    logic [7:0]       r_rd_data, w_rd_data;
    logic [1:0]       r_rd_vld,  w_rd_vld;
    logic [1:0]       r_done,    w_done;
    logic             r_err_o,   w_err_o;
    logic [1:0]       r_grant,   w_grant;
    logic             r_m_en,    w_m_en;
    logic             r_m_start, w_m_start;
    logic             r_m_stop,  w_m_stop;
    logic             r_m_mode,  w_m_mode;
    logic [6:0]       r_m_addr,  w_m_addr;
    logic [7:0]       r_m_wdata, w_m_wdata;
    logic             w_win;
    logic [1:0]       w_sel;
    logic [7:0]       w_owner_wdata;

    assign w_sel         = r_owner ? 2'b10 : 2'b01;
    assign w_owner_wdata = r_owner ? bus.wdata1 : bus.wdata0;

    // Single requester wins outright; a tie goes to whoever was not served last.
    always_comb begin
        if (bus.req == 2'b01)      w_win = 1'b0;
        else if (bus.req == 2'b10) w_win = 1'b1;
        else                       w_win = ~r_last;
    end

    always_comb begin
        w_state   = r_state;
        w_owner   = r_owner;
        w_last    = r_last;
        w_addr    = r_addr;
        w_rnw     = r_rnw;
        w_len     = r_len;
        w_cnt     = r_cnt;
        w_err     = r_err;
        w_wd      = r_wd;
        w_rd_data = r_rd_data;
        w_grant   = r_grant;
        w_m_en    = r_m_en;
        w_m_stop  = r_m_stop;
        w_m_mode  = r_m_mode;
        w_m_addr  = r_m_addr;
        w_m_wdata = r_m_wdata;
        w_wr_ack  = 2'b00;
        w_rd_vld  = 2'b00;
        w_done    = 2'b00;
        w_err_o   = 1'b0;
        w_m_start = 1'b0;
        // The requester advances wdata on the wr_ack edge; pick it up one cycle later.
        w_wload   = |r_wr_ack;
        if (r_wload) w_m_wdata = w_owner_wdata;

        case (r_state)
            S_IDLE: begin
                if (bus.req != 2'b00 && bus.m_idle) begin
                    w_owner = w_win;
                    w_grant = w_win ? 2'b10 : 2'b01;
                    w_addr  = w_win ? bus.addr1 : bus.addr0;
                    w_rnw   = bus.rnw[w_win];
                    w_len   = w_win ? bus.len1 : bus.len0;
                    w_state = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_m_en    = 1'b1;
                w_m_start = 1'b1;
                w_m_mode  = r_rnw;
                w_m_addr  = r_addr;
                w_m_wdata = w_owner_wdata;
                w_cnt     = (r_len == '0) ? c_CNT_ONE : r_len;
                w_m_stop  = (w_cnt == c_CNT_ONE);
                w_err     = 1'b0;
                w_wd      = '0;
                w_state   = S_XFER;
            end
            S_XFER: begin
                if (bus.m_nack) begin
                    w_err    = 1'b1;
                    w_m_stop = 1'b1;
                    w_state  = S_WAIT;
                end else if (bus.m_byte_done) begin
                    w_wd = '0;
                    if (r_rnw) begin
                        w_rd_data = bus.m_rdata;
                        w_rd_vld  = w_sel;
                    end else begin
                        w_wr_ack  = w_sel;
                    end
                    if (r_cnt != '0) w_cnt = r_cnt - c_CNT_ONE;
                    if (w_cnt == c_CNT_ONE) w_m_stop = 1'b1;
                    if (w_cnt == '0)        w_state  = S_WAIT;
                end else if (r_wd == c_WD_LAST) begin
                    w_m_en   = 1'b0;
                    w_m_stop = 1'b0;
                    w_grant  = 2'b00;
                    w_done   = w_sel;
                    w_err_o  = 1'b1;
                    w_last   = r_owner;
                    w_state  = S_IDLE;
                end else begin
                    w_wd = r_wd + TO_W'(1);
                end
            end
            default: begin
                if (bus.m_idle || r_wd == c_WD_LAST) begin
                    w_m_en   = 1'b0;
                    w_m_stop = 1'b0;
                    w_grant  = 2'b00;
                    w_done   = w_sel;
                    w_err_o  = r_err | ~bus.m_idle;
                    w_last   = r_owner;
                    w_state  = S_IDLE;
                end else if (bus.m_byte_done) begin
                    w_wd = '0;
                end else begin
                    w_wd = r_wd + TO_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_rnw     <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_wd      <= '0;
            r_wload   <= 1'b0;
            r_wr_ack  <= 2'b00;
            r_rd_data <= '0;
            r_rd_vld  <= 2'b00;
            r_done    <= 2'b00;
            r_err_o   <= 1'b0;
            r_grant   <= 2'b00;
            r_m_en    <= 1'b0;
            r_m_start <= 1'b0;
            r_m_stop  <= 1'b0;
            r_m_mode  <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_last    <= w_last;
            r_addr    <= w_addr;
            r_rnw     <= w_rnw;
            r_len     <= w_len;
            r_cnt     <= w_cnt;
            r_err     <= w_err;
            r_wd      <= w_wd;
            r_wload   <= w_wload;
            r_wr_ack  <= w_wr_ack;
            r_rd_data <= w_rd_data;
            r_rd_vld  <= w_rd_vld;
            r_done    <= w_done;
            r_err_o   <= w_err_o;
            r_grant   <= w_grant;
            r_m_en    <= w_m_en;
            r_m_start <= w_m_start;
            r_m_stop  <= w_m_stop;
            r_m_mode  <= w_m_mode;
            r_m_addr  <= w_m_addr;
            r_m_wdata <= w_m_wdata;
        end
    end

    assign bus.wr_ack    = r_wr_ack;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_vld    = r_rd_vld;
    assign bus.done      = r_done;
    assign bus.err       = r_err_o;
    assign bus.grant     = r_grant;
    assign bus.m_en      = r_m_en;
    assign bus.m_start   = r_m_start;
    assign bus.m_stop    = r_m_stop;
    assign bus.m_mode    = r_m_mode;
    assign bus.m_address = r_m_addr;
    assign bus.m_wdata   = r_m_wdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_scheduler.sv
// ============================================================================
// Module   : tb_i2c_req_scheduler
// Brief    : Scoreboard bench for i2c_req_scheduler with a behavioural I2C
//            master core and two queue-fed requesters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_req_scheduler;
    localparam int LEN_W   = 4;
    localparam int TO_W    = 10;
    localparam int TIMEOUT = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    i2c_req_scheduler_if #(.LEN_W(LEN_W)) bif ();

    i2c_req_scheduler #(.LEN_W(LEN_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_wr[$];     // bytes the master must see on m_wdata
    logic       exp_stop[$];   // m_stop level expected at each byte completion
    logic [7:0] rd_src[$];     // bytes the master returns on reads
    logic [9:0] exp_rd[$];     // {rd_vld, rd_data}
    logic [2:0] exp_done[$];   // {done, err}
    logic [1:0] exp_grant[$];
    logic [7:0] exp_start[$];  // {m_mode, m_address}
    logic [7:0] wq0[$];
    logic [7:0] wq1[$];

    int pend0 = 0, pend1 = 0;
    int n_done = 0, n_start = 0, n_grant = 0, n_rd = 0, wack0 = 0, wack1 = 0;
    bit nack_addr = 1'b0, mute = 1'b0, stop_seen = 1'b0;

    // Requesters and output monitor
    initial begin : monitor
        logic [1:0] prev_grant;
        logic       prev_start;
        logic [9:0] er;
        logic [2:0] ed;
        logic [1:0] eg;
        prev_grant = 2'b00;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bif.wr_ack[0]) begin wack0++; if (wq0.size() > 0) void'(wq0.pop_front()); end
                if (bif.wr_ack[1]) begin wack1++; if (wq1.size() > 0) void'(wq1.pop_front()); end
                if (bif.rd_vld != 2'b00) begin
                    n_rd++;
                    n_checks++;
                    er = (exp_rd.size() > 0) ? exp_rd.pop_front() : 10'h3FF;
                    if ({bif.rd_vld, bif.rd_data} !== er) begin
                        n_fail++;
                        $display("FAIL rd_vld_data: got vld=%b data=%h, required vld=%b data=%h",
                                 bif.rd_vld, bif.rd_data, er[9:8], er[7:0]);
                    end
                end
                if (bif.done != 2'b00) begin
                    n_done++;
                    n_checks++;
                    ed = (exp_done.size() > 0) ? exp_done.pop_front() : 3'b111;
                    if ({bif.done, bif.err} !== ed) begin
                        n_fail++;
                        $display("FAIL done_err: got done=%b err=%b, required done=%b err=%b",
                                 bif.done, bif.err, ed[2:1], ed[0]);
                    end
                    if (bif.done[0] && pend0 > 0) pend0--;
                    if (bif.done[1] && pend1 > 0) pend1--;
                end
                if (bif.grant != prev_grant && bif.grant != 2'b00) begin
                    n_grant++;
                    n_checks++;
                    eg = (exp_grant.size() > 0) ? exp_grant.pop_front() : 2'b11;
                    if (bif.grant !== eg) begin
                        n_fail++;
                        $display("FAIL grant_order: got %b, required %b", bif.grant, eg);
                    end
                end
                if (bif.m_start && prev_start) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL m_start_width: got high 2+ cycles, required 1 cycle");
                end
            end
            prev_grant = bif.grant;
            prev_start = bif.m_start;
            bif.wdata0 = (wq0.size() > 0) ? wq0[0] : 8'h00;
            bif.wdata1 = (wq1.size() > 0) ? wq1[0] : 8'h00;
            bif.req    = {pend1 > 0, pend0 > 0};
        end
    end

    // Behavioural master core: address phase, 4-cycle bytes, 3-cycle stop
    initial begin : master_model
        int         phase, tmr;
        logic       cur_mode;
        logic [7:0] e8;
        logic       es;
        phase = 0; tmr = 0; cur_mode = 1'b0;
        bif.m_idle = 1'b1; bif.m_byte_done = 1'b0; bif.m_nack = 1'b0; bif.m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bif.m_byte_done = 1'b0;
            bif.m_nack      = 1'b0;
            if (!reset_n) begin
                phase = 0; tmr = 0; bif.m_idle = 1'b1;
            end else if (phase == 0) begin
                if (bif.m_start) begin
                    n_start++;
                    phase = 1; tmr = 0; bif.m_idle = 1'b0; cur_mode = bif.m_mode;
                    n_checks++;
                    e8 = (exp_start.size() > 0) ? exp_start.pop_front() : 8'hFF;
                    if ({bif.m_mode, bif.m_address} !== e8) begin
                        n_fail++;
                        $display("FAIL start_mode_addr: got mode=%b addr=%h, required mode=%b addr=%h",
                                 bif.m_mode, bif.m_address, e8[7], e8[6:0]);
                    end
                end
            end else if ((phase == 1 || phase == 2) && !bif.m_en) begin
                phase = 0; bif.m_idle = 1'b1;
            end else if (phase == 1) begin
                tmr++;
                if (tmr == 2) begin
                    tmr = 0;
                    if (nack_addr) begin bif.m_nack = 1'b1; phase = 3; end
                    else phase = 2;
                end
            end else if (phase == 2) begin
                if (!mute) begin
                    tmr++;
                    if (tmr == 4) begin
                        tmr = 0;
                        bif.m_byte_done = 1'b1;
                        if (!cur_mode) begin
                            n_checks++;
                            e8 = (exp_wr.size() > 0) ? exp_wr.pop_front() : 8'hXX;
                            if (bif.m_wdata !== e8) begin
                                n_fail++;
                                $display("FAIL m_wdata: got %h, required %h", bif.m_wdata, e8);
                            end
                        end else begin
                            bif.m_rdata = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
                        end
                        n_checks++;
                        es = (exp_stop.size() > 0) ? exp_stop.pop_front() : 1'bx;
                        if (bif.m_stop !== es) begin
                            n_fail++;
                            $display("FAIL m_stop_at_byte: got %b, required %b", bif.m_stop, es);
                        end
                        if (bif.m_stop) phase = 3;
                    end
                end
            end else begin
                tmr++;
                if (tmr == 2) stop_seen = bif.m_stop;
                if (tmr == 3) begin tmr = 0; phase = 0; bif.m_idle = 1'b1; end
            end
        end
    end

    task automatic check_drained(input string name);
        int left;
        left = exp_wr.size() + exp_stop.size() + exp_rd.size() + exp_done.size()
             + exp_grant.size() + exp_start.size();
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d expected events outstanding, required 0", name, left);
        end
    endtask

    task automatic wait_done(input string name, input int target);
        for (int c = 0; c < 800 && n_done < target; c++) @(negedge clk);
        n_checks++;
        if (n_done < target) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d done pulses, required %0d", name, n_done, target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bif.grant, bif.m_en, bif.m_start, bif.m_stop, bif.done, bif.err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {bif.grant, bif.m_en, bif.m_start, bif.m_stop, bif.done, bif.err});
        end
        n_checks++;
        if ({bif.wr_ack, bif.rd_vld, bif.rd_data, bif.m_address, bif.m_wdata, bif.m_mode} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0",
                     {bif.wr_ack, bif.rd_vld, bif.rd_data, bif.m_address, bif.m_wdata, bif.m_mode});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bif.grant, bif.m_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got grant=%b m_en=%b, required 00/0", bif.grant, bif.m_en);
        end
    endtask

    task automatic test_write();
        int d0, w0, s0;
        d0 = n_done; w0 = wack0; s0 = n_start;
        wq0.push_back(8'hA1); wq0.push_back(8'hA2);
        exp_wr.push_back(8'hA1); exp_wr.push_back(8'hA2);
        exp_stop.push_back(1'b0); exp_stop.push_back(1'b1);
        exp_start.push_back({1'b0, 7'h2A});
        exp_grant.push_back(2'b01);
        exp_done.push_back({2'b01, 1'b0});
        bif.rnw[0] = 1'b0; bif.addr0 = 7'h2A; bif.len0 = 4'd2;
        pend0 = 1;
        wait_done("write", d0 + 1);
        n_checks++;
        if (wack0 - w0 != 2 || n_start - s0 != 1) begin
            n_fail++;
            $display("FAIL write_counts: got wr_ack=%0d starts=%0d, required 2/1", wack0 - w0, n_start - s0);
        end
        check_drained("write");
    endtask

    task automatic test_read();
        int d0, r0;
        d0 = n_done; r0 = n_rd; stop_seen = 1'b0;
        rd_src.push_back(8'h11); rd_src.push_back(8'h22); rd_src.push_back(8'h33);
        exp_rd.push_back({2'b10, 8'h11}); exp_rd.push_back({2'b10, 8'h22}); exp_rd.push_back({2'b10, 8'h33});
        exp_stop.push_back(1'b0); exp_stop.push_back(1'b0); exp_stop.push_back(1'b1);
        exp_start.push_back({1'b1, 7'h35});
        exp_grant.push_back(2'b10);
        exp_done.push_back({2'b10, 1'b0});
        bif.rnw[1] = 1'b1; bif.addr1 = 7'h35; bif.len1 = 4'd3;
        pend1 = 1;
        wait_done("read", d0 + 1);
        n_checks++;
        if (n_rd - r0 != 3 || stop_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL read_counts: got rd_vld=%0d stop_held=%b, required 3/1", n_rd - r0, stop_seen);
        end
        check_drained("read");
    endtask

    task automatic test_back_to_back();
        int d0, g0, w0;
        d0 = n_done; g0 = n_grant; w0 = wack0;
        wq0.push_back(8'hB1); wq0.push_back(8'hB2);
        rd_src.push_back(8'h5A);
        exp_grant.push_back(2'b01); exp_grant.push_back(2'b10); exp_grant.push_back(2'b01);
        exp_start.push_back({1'b0, 7'h10}); exp_start.push_back({1'b1, 7'h11}); exp_start.push_back({1'b0, 7'h10});
        exp_wr.push_back(8'hB1); exp_wr.push_back(8'hB2);
        exp_rd.push_back({2'b10, 8'h5A});
        repeat (3) exp_stop.push_back(1'b1);
        exp_done.push_back({2'b01, 1'b0}); exp_done.push_back({2'b10, 1'b0}); exp_done.push_back({2'b01, 1'b0});
        bif.rnw = 2'b10; bif.addr0 = 7'h10; bif.addr1 = 7'h11; bif.len0 = 4'd1; bif.len1 = 4'd1;
        pend0 = 2; pend1 = 1;
        wait_done("b2b", d0 + 3);
        n_checks++;
        if (n_grant - g0 != 3 || wack0 - w0 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got grants=%0d wr_ack0=%0d, required 3/2", n_grant - g0, wack0 - w0);
        end
        check_drained("b2b");
    endtask

    task automatic test_nack();
        int d0, w0, w1, r0;
        d0 = n_done; w0 = wack0; w1 = wack1; r0 = n_rd; stop_seen = 1'b0;
        nack_addr = 1'b1;
        wq0.push_back(8'hC1); wq0.push_back(8'hC2);
        exp_start.push_back({1'b0, 7'h50});
        exp_grant.push_back(2'b01);
        exp_done.push_back({2'b01, 1'b1});
        bif.rnw[0] = 1'b0; bif.addr0 = 7'h50; bif.len0 = 4'd2;
        pend0 = 1;
        wait_done("nack", d0 + 1);
        n_checks++;
        if (wack0 - w0 != 0 || n_rd - r0 != 0 || stop_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL nack_quiet: got wr_ack=%0d rd_vld=%0d stop=%b, required 0/0/1",
                     wack0 - w0, n_rd - r0, stop_seen);
        end
        nack_addr = 1'b0;
        wq0.delete();
        wq1.push_back(8'hD1);
        exp_wr.push_back(8'hD1);
        exp_stop.push_back(1'b1);
        exp_start.push_back({1'b0, 7'h51});
        exp_grant.push_back(2'b10);
        exp_done.push_back({2'b10, 1'b0});
        bif.rnw[1] = 1'b0; bif.addr1 = 7'h51; bif.len1 = 4'd1;
        pend1 = 1;
        wait_done("after_nack", d0 + 2);
        n_checks++;
        if (wack1 - w1 != 1) begin
            n_fail++;
            $display("FAIL after_nack_ack: got wr_ack1=%0d, required 1", wack1 - w1);
        end
        check_drained("nack");
    endtask

    task automatic test_timeout();
        int d0, en_cycles;
        d0 = n_done; mute = 1'b1;
        wq1.push_back(8'hE1);
        exp_start.push_back({1'b0, 7'h60});
        exp_grant.push_back(2'b10);
        exp_done.push_back({2'b10, 1'b1});
        bif.rnw[1] = 1'b0; bif.addr1 = 7'h60; bif.len1 = 4'd1;
        pend1 = 1;
        for (int c = 0; c < 100 && !bif.m_en; c++) @(negedge clk);
        en_cycles = 0;
        for (int c = 0; c < 200 && bif.m_en; c++) begin en_cycles++; @(negedge clk); end
        n_checks++;
        if (en_cycles != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_m_en_cycles: got %0d, required %0d", en_cycles, TIMEOUT);
        end
        wait_done("timeout", d0 + 1);
        mute = 1'b0;
        wq1.delete();
        check_drained("timeout");
    endtask

    task automatic test_len_bounds();
        int d0, r0, w1;
        d0 = n_done; r0 = n_rd; w1 = wack1;
        wq1.push_back(8'hF0);
        exp_wr.push_back(8'hF0);
        exp_stop.push_back(1'b1);
        exp_start.push_back({1'b0, 7'h0F});
        exp_grant.push_back(2'b10);
        exp_done.push_back({2'b10, 1'b0});
        bif.rnw[1] = 1'b0; bif.addr1 = 7'h0F; bif.len1 = 4'd0;
        pend1 = 1;
        wait_done("len0", d0 + 1);
        for (int i = 0; i < 15; i++) begin
            rd_src.push_back(8'(i * 7 + 3));
            exp_rd.push_back({2'b01, 8'(i * 7 + 3)});
            exp_stop.push_back(i == 14);
        end
        exp_start.push_back({1'b1, 7'h70});
        exp_grant.push_back(2'b01);
        exp_done.push_back({2'b01, 1'b0});
        bif.rnw[0] = 1'b1; bif.addr0 = 7'h70; bif.len0 = 4'd15;
        pend0 = 1;
        wait_done("len15", d0 + 2);
        n_checks++;
        if (n_rd - r0 != 15 || wack1 - w1 != 1) begin
            n_fail++;
            $display("FAIL len_bounds_counts: got rd_vld=%0d wr_ack1=%0d, required 15/1", n_rd - r0, wack1 - w1);
        end
        check_drained("len");
    endtask

    task automatic test_reset_mid();
        int d0, w0;
        w0 = wack0;
        wq0.push_back(8'h01); wq0.push_back(8'h02); wq0.push_back(8'h03);
        exp_wr.push_back(8'h01); exp_wr.push_back(8'h02); exp_wr.push_back(8'h03);
        exp_stop.push_back(1'b0); exp_stop.push_back(1'b0); exp_stop.push_back(1'b1);
        exp_start.push_back({1'b0, 7'h22});
        exp_grant.push_back(2'b01);
        bif.rnw[0] = 1'b0; bif.addr0 = 7'h22; bif.len0 = 4'd3;
        pend0 = 1;
        for (int c = 0; c < 200 && wack0 == w0; c++) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bif.grant, bif.m_en, bif.m_start, bif.m_stop, bif.m_mode, bif.m_address, bif.m_wdata,
             bif.wr_ack, bif.rd_vld, bif.done, bif.err, bif.rd_data} !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got grant=%b m_en=%b m_stop=%b addr=%h wdata=%h, required all 0",
                     bif.grant, bif.m_en, bif.m_stop, bif.m_address, bif.m_wdata);
        end
        pend0 = 0;
        wq0.delete(); exp_wr.delete(); exp_stop.delete(); exp_start.delete(); exp_grant.delete();
        d0 = n_done;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bif.grant !== 2'b00 || n_done != d0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got grant=%b done_pulses=%0d, required 00/0", bif.grant, n_done - d0);
        end
        wq0.push_back(8'h44);
        exp_wr.push_back(8'h44);
        exp_stop.push_back(1'b1);
        exp_start.push_back({1'b0, 7'h23});
        exp_grant.push_back(2'b01);
        exp_done.push_back({2'b01, 1'b0});
        bif.addr0 = 7'h23; bif.len0 = 4'd1;
        pend0 = 1;
        wait_done("reset_restart", d0 + 1);
        check_drained("reset_mid");
    endtask

    initial begin : main
        bif.rnw = 2'b00; bif.addr0 = '0; bif.addr1 = '0; bif.len0 = '0; bif.len1 = '0;
        bif.req = 2'b00; bif.wdata0 = '0; bif.wdata1 = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_len_bounds();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
